// File: rtl/fixed4_pkg.sv
// Shared types for the fixed-4 column accumulator: FSM states, result-buffer
// entry tag and the psum width helper.
package fixed4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_FLUSH
    } state_t;

    // Flags stored in front of the ACC_WIDTH data word in each buffer entry.
    typedef struct packed {
        logic partial;
        logic sat;
    } entry_tag_t;

    localparam int ENTRY_TAG_W = 2;

    function automatic int psum_width(input int col_width);
        return 2 * col_width;
    endfunction

endpackage

// File: rtl/fixed4_acc_fifo2.sv
// Two-entry valid/ready FIFO; head entry is always presented on head_o.
module fixed4_acc_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       count_q;
    logic             do_pop;
    logic             do_push;
    logic             write_tail;

    assign do_pop     = pop_i && (count_q != 2'd0);
    assign do_push    = push_i && ((count_q != 2'd2) || do_pop);
    // Slot for the new entry is chosen by how many entries survive the pop.
    assign write_tail = (count_q - {1'b0, do_pop}) != 2'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            if (do_pop) begin
                head_q <= tail_q;
            end
            if (do_push) begin
                if (write_tail) begin
                    tail_q <= push_data_i;
                end else begin
                    head_q <= push_data_i;
                end
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head_o  = head_q;
    assign valid_o = count_q != 2'd0;
    assign count_o = count_q;

endmodule

// File: rtl/fixed4_col_accum.sv
// Column-bottom accumulator: sums a programmable number of psums per group with
// saturation, and hands results to writeback through a 2-entry buffer.
module fixed4_col_accum
    import fixed4_pkg::*;
#(
    parameter int COL_WIDTH = 11,
    parameter int ACC_WIDTH = 32,
    parameter int PASS_BITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_start,
    input  logic [PASS_BITS-1:0]   cfg_passes,
    input  logic                   cfg_signed,
    input  logic                   cfg_flush,
    input  logic                   psum_valid,
    output logic                   psum_ready,
    input  logic [2*COL_WIDTH-1:0] psum_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_data,
    output logic                   out_sat,
    output logic                   out_partial,
    output logic                   busy
);

    localparam int PSUM_W  = psum_width(COL_WIDTH);
    localparam int ENTRY_W = ACC_WIDTH + ENTRY_TAG_W;
    localparam logic [PASS_BITS-1:0] PASS_ONE = {{(PASS_BITS-1){1'b0}}, 1'b1};

    state_t                 state_q;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic [PASS_BITS-1:0]   cnt_q;
    logic [PASS_BITS-1:0]   passes_q;
    logic                   signed_q;
    logic                   sat_q;

    logic [1:0]             fifo_count;
    logic [ENTRY_W-1:0]     fifo_head;
    logic [ENTRY_W-1:0]     push_entry;
    logic                   push;
    logic                   accept;
    logic                   last_beat;
    logic [ACC_WIDTH:0]     ext;
    logic [ACC_WIDTH:0]     acc_ext;
    logic [ACC_WIDTH:0]     sum;
    logic [ACC_WIDTH-1:0]   clamped;
    logic                   clamp_hit;
    entry_tag_t             push_tag;
    entry_tag_t             head_tag;

    assign psum_ready = (state_q == ST_ACCUM) && (fifo_count != 2'd2);
    assign accept     = psum_valid && psum_ready;
    assign last_beat  = cnt_q == (passes_q - PASS_ONE);

    assign ext = signed_q ? {{(ACC_WIDTH+1-PSUM_W){psum_in[PSUM_W-1]}}, psum_in}
                          : {{(ACC_WIDTH+1-PSUM_W){1'b0}}, psum_in};
    assign acc_ext = signed_q ? {acc_q[ACC_WIDTH-1], acc_q} : {1'b0, acc_q};
    assign sum     = acc_ext + ext;

    // Signed overflow shows as the two top bits disagreeing; unsigned as a carry.
    always_comb begin
        clamped   = sum[ACC_WIDTH-1:0];
        clamp_hit = 1'b0;
        if (signed_q) begin
            if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
                clamp_hit = 1'b1;
                clamped   = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                           : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end else if (sum[ACC_WIDTH]) begin
            clamp_hit = 1'b1;
            clamped   = '1;
        end
    end

    always_comb begin
        push             = 1'b0;
        push_tag.partial = 1'b0;
        push_tag.sat     = sat_q | clamp_hit;
        push_entry       = {push_tag, clamped};
        if (accept && last_beat) begin
            push = 1'b1;
        end else if ((state_q == ST_FLUSH) && (cnt_q != '0) && (fifo_count != 2'd2)) begin
            push             = 1'b1;
            push_tag.partial = 1'b1;
            push_tag.sat     = sat_q;
            push_entry       = {push_tag, acc_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            passes_q <= PASS_ONE;
            signed_q <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_start) begin
                        passes_q <= (cfg_passes == '0) ? PASS_ONE : cfg_passes;
                        signed_q <= cfg_signed;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        sat_q    <= 1'b0;
                        state_q  <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        if (last_beat) begin
                            acc_q <= '0;
                            cnt_q <= '0;
                            sat_q <= 1'b0;
                        end else begin
                            acc_q <= clamped;
                            cnt_q <= cnt_q + PASS_ONE;
                            sat_q <= sat_q | clamp_hit;
                        end
                    end
                    if (cfg_flush) begin
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else if (fifo_count != 2'd2) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        sat_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    fixed4_acc_fifo2 #(
        .WIDTH(ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (out_ready),
        .head_o      (fifo_head),
        .valid_o     (out_valid),
        .count_o     (fifo_count)
    );

    assign head_tag    = entry_tag_t'(fifo_head[ENTRY_W-1 -: ENTRY_TAG_W]);
    assign out_data    = fifo_head[ACC_WIDTH-1:0];
    assign out_sat     = head_tag.sat;
    assign out_partial = head_tag.partial;
    assign busy        = (state_q != ST_IDLE) || (fifo_count != 2'd0);

endmodule

// File: tb/tb_fixed4_col_accum.sv
// Directed bench for fixed4_col_accum: a 32-bit and a 24-bit accumulator share
// every input so the saturation case can be compared against the wide result.
module tb_fixed4_col_accum;

    logic        clk;
    logic        rst;
    logic        cfg_start;
    logic [3:0]  cfg_passes;
    logic        cfg_signed;
    logic        cfg_flush;
    logic        psum_valid;
    logic [21:0] psum_in;
    logic        out_ready;

    logic        psum_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_sat;
    logic        out_partial;
    logic        busy;

    logic        psum_ready24;
    logic        out_valid24;
    logic [23:0] out_data24;
    logic        out_sat24;
    logic        out_partial24;
    logic        busy24;

    int checkCount = 0;
    int errorCount = 0;

    fixed4_col_accum #(.COL_WIDTH(11), .ACC_WIDTH(32), .PASS_BITS(4)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_passes(cfg_passes),
        .cfg_signed(cfg_signed), .cfg_flush(cfg_flush), .psum_valid(psum_valid),
        .psum_ready(psum_ready), .psum_in(psum_in), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .out_partial(out_partial), .busy(busy)
    );

    fixed4_col_accum #(.COL_WIDTH(11), .ACC_WIDTH(24), .PASS_BITS(4)) dut24 (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_passes(cfg_passes),
        .cfg_signed(cfg_signed), .cfg_flush(cfg_flush), .psum_valid(psum_valid),
        .psum_ready(psum_ready24), .psum_in(psum_in), .out_valid(out_valid24),
        .out_ready(out_ready), .out_data(out_data24), .out_sat(out_sat24),
        .out_partial(out_partial24), .busy(busy24)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startRun(input logic [3:0] passes, input logic sgn);
        cfg_passes = passes;
        cfg_signed = sgn;
        cfg_start  = 1'b1;
        tick();
        cfg_start  = 1'b0;
    endtask

    // Ends the current run; with an empty group this only returns to IDLE.
    task automatic flushRun();
        cfg_flush = 1'b1;
        tick();
        cfg_flush = 1'b0;
        tick();
    endtask

    task automatic popOne();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic applyStimulus(input logic [21:0] value);
        bit done;
        done       = 1'b0;
        psum_valid = 1'b1;
        psum_in    = value;
        for (int i = 0; i < 50 && !done; i++) begin
            if (psum_ready) done = 1'b1;
            tick();
        end
        psum_valid = 1'b0;
        if (!done) checkOutput("beat_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        rst        = 1'b1;
        cfg_start  = 1'b0;
        cfg_passes = 4'd0;
        cfg_signed = 1'b0;
        cfg_flush  = 1'b0;
        psum_valid = 1'b0;
        psum_in    = '0;
        out_ready  = 1'b0;
        tick();
        tick();
        checkOutput("rst_psum_ready", psum_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_sat", out_sat, 0);
        checkOutput("rst_out_partial", out_partial, 0);
        checkOutput("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        // Signed: -1 + 5 + 100
        startRun(4'd3, 1'b1);
        applyStimulus(22'h3FFFFF);
        applyStimulus(22'd5);
        checkOutput("s3_not_yet", out_valid, 0);
        applyStimulus(22'd100);
        checkOutput("s3_valid", out_valid, 1);
        checkOutput("s3_data", out_data, 104);
        checkOutput("s3_sat", out_sat, 0);
        checkOutput("s3_partial", out_partial, 0);
        popOne();
        checkOutput("s3_popped", out_valid, 0);

        // Unsigned: 2 * 4194303
        flushRun();
        startRun(4'd2, 1'b0);
        applyStimulus(22'h3FFFFF);
        applyStimulus(22'h3FFFFF);
        checkOutput("u2_data", out_data, 8388606);
        checkOutput("u2_data24", out_data24, 8388606);
        popOne();

        // Signed 5 * 2097151 clamps at 24 bits but not at 32
        flushRun();
        startRun(4'd5, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(22'h1FFFFF);
        checkOutput("sat_data24", out_data24, 8388607);
        checkOutput("sat_flag24", out_sat24, 1);
        checkOutput("sat_data32", out_data, 10485755);
        checkOutput("sat_flag32", out_sat, 0);
        popOne();
        for (int i = 0; i < 5; i++) applyStimulus(22'd1);
        checkOutput("sat_next_data24", out_data24, 5);
        checkOutput("sat_next_flag24", out_sat24, 0);
        popOne();

        // Backpressure with passes=1: buffer fills after two results
        flushRun();
        startRun(4'd1, 1'b0);
        psum_valid = 1'b1;
        psum_in    = 22'd11;
        checkOutput("bp_ready1", psum_ready, 1);
        tick();
        psum_in = 22'd22;
        checkOutput("bp_ready2", psum_ready, 1);
        tick();
        psum_in = 22'd33;
        checkOutput("bp_ready3", psum_ready, 0);
        tick();
        checkOutput("bp_ready4", psum_ready, 0);
        checkOutput("bp_head11", out_data, 11);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("bp_head22", out_data, 22);
        checkOutput("bp_ready_after_pop", psum_ready, 1);
        tick();
        psum_valid = 1'b0;
        checkOutput("bp_hold22", out_data, 22);
        checkOutput("bp_full_again", psum_ready, 0);
        out_ready = 1'b1;
        tick();
        checkOutput("bp_head33", out_data, 33);
        tick();
        out_ready = 1'b0;
        checkOutput("bp_empty", out_valid, 0);

        // passes=0 behaves as a single-beat group
        flushRun();
        startRun(4'd0, 1'b0);
        applyStimulus(22'd9);
        checkOutput("p0_valid", out_valid, 1);
        checkOutput("p0_data", out_data, 9);
        popOne();

        // Flush of a partial group 7 + 8
        flushRun();
        startRun(4'd4, 1'b0);
        applyStimulus(22'd7);
        applyStimulus(22'd8);
        cfg_flush = 1'b1;
        tick();
        cfg_flush = 1'b0;
        checkOutput("fl_n1_valid", out_valid, 0);
        tick();
        checkOutput("fl_valid", out_valid, 1);
        checkOutput("fl_data", out_data, 15);
        checkOutput("fl_partial", out_partial, 1);
        checkOutput("fl_idle_ready", psum_ready, 0);
        checkOutput("fl_busy_held", busy, 1);
        popOne();
        checkOutput("fl_popped", out_valid, 0);
        checkOutput("fl_busy_low", busy, 0);

        // Flush with nothing accumulated emits nothing
        startRun(4'd4, 1'b0);
        flushRun();
        tick();
        checkOutput("fl0_valid", out_valid, 0);
        checkOutput("fl0_busy", busy, 0);

        // Reset mid-group, then a clean group 1+2+3+4
        startRun(4'd4, 1'b0);
        applyStimulus(22'd1);
        applyStimulus(22'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mr_valid", out_valid, 0);
        checkOutput("mr_ready", psum_ready, 0);
        startRun(4'd4, 1'b0);
        for (int i = 1; i <= 4; i++) applyStimulus(22'(i));
        checkOutput("mr_data", out_data, 10);
        checkOutput("mr_partial", out_partial, 0);
        popOne();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/fixed4_col_accum.md
# fixed4_col_accum

Column-bottom accumulator for the fixed-4 PE array. Consumes the partial sum leaving the last PE of a column (`psum_fwd` of the bottom `fixed4`) and accumulates a programmable number of passes into a wide result. Output goes through a 2-entry buffer with a valid/ready handshake to the writeback stage. Saturates on overflow, flags saturation, and supports flushing a partially accumulated group.

## Interface
- `COL_WIDTH`, 11: PE column width; input psum is `2*COL_WIDTH` bits.
- `ACC_WIDTH`, 32: accumulator and result width; must be > `2*COL_WIDTH`.
- `PASS_BITS`, 4: width of the pass-count field.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_start` in 1: pulse; starts accumulation (IDLE only).
- `cfg_passes` in PASS_BITS: psums per output group, sampled on `cfg_start`; 0 is treated as 1.
- `cfg_signed` in 1: sampled on `cfg_start`; 1 = psum and accumulator are signed (`s_in|s_weight`), 0 = unsigned.
- `cfg_flush` in 1: pulse; ends the run and emits any partial group.
- `psum_valid` in 1, `psum_ready` out 1, `psum_in` in 2*COL_WIDTH: input handshake.
- `out_valid` out 1, `out_ready` in 1, `out_data` out ACC_WIDTH: result handshake.
- `out_sat` out 1: saturation occurred in this group.
- `out_partial` out 1: result came from a flush before the group completed.
- `busy` out 1: high when the state is not IDLE or the buffer is non-empty.

## Operation
- FSM states: IDLE, ACCUM, FLUSH.
  - IDLE→ACCUM on `cfg_start`. This latches passes/signed and clears the accumulator, the counter and the sticky sat bit.
  - `cfg_start` is ignored in ACCUM and FLUSH.
- Beat acceptance: a beat is accepted when `psum_valid & psum_ready`.
  - `psum_ready` = (state==ACCUM) && (buffer count < 2).
- Extension: `psum_in` is sign-extended if `cfg_signed`, otherwise zero-extended, to ACC_WIDTH+1.
- Sum: `sum = acc + ext`, computed in ACC_WIDTH+1 bits and then clamped.
  - Signed mode: clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Unsigned mode: clamp to [0, 2^ACC_WIDTH-1].
  - Any clamp sets the sticky sat bit.
- Non-last accepted beat: `acc <= clamped sum`, counter increments.
- Last accepted beat (counter == passes-1):
  - {partial=0, sat, clamped sum} is pushed into the buffer in the same cycle.
  - acc, counter and sat clear.
  - State stays ACCUM for the next group.
- `cfg_flush` in ACCUM → FLUSH.
  - A beat accepted in the same cycle is included first. If that beat completes the group, the result is pushed as a normal result.
- FLUSH with counter > 0: wait until buffer count < 2, push {partial=1, sat, acc}, then go to IDLE.
- FLUSH with counter == 0: go to IDLE next cycle with no push.
- `cfg_flush` in IDLE or FLUSH is ignored.
- Buffer: 2-entry FIFO.
  - `out_*` present the head entry.
  - Pop on `out_valid & out_ready`.
  - Push and pop in the same cycle are allowed at any count.
- Reset: state IDLE, buffer emptied, acc/counter/sat cleared, regardless of in-flight data.
  - Reset values of all outputs: `psum_ready`=0, `out_valid`=0, `out_data`=0, `out_sat`=0, `out_partial`=0, `busy`=0.

## Timing
- `psum_ready` is registered-state-derived; it does not depend combinationally on `psum_valid`.
- Latency: last beat accepted in cycle N → `out_valid` high in cycle N+1 (buffer previously empty).
- Throughput: one beat per cycle while the buffer drains at one result per group.
- Flush: `cfg_flush` in cycle N with counter>0 and buffer room → partial result valid at N+2, state IDLE at N+2.
- `out_data`/`out_sat`/`out_partial` hold stable while `out_valid & !out_ready`.
- `busy` falls in the cycle after the final pop in IDLE.

## Structure
- Shared package `fixed4_pkg`:
  - FSM state enum.
  - Buffer entry struct {partial, sat, data}.
  - `PSUM_W = 2*COL_WIDTH` helper.
- One sub-module: `fixed4_acc_fifo2`, a 2-entry valid/ready FIFO parameterised on entry width. Everything else is in the top.

## Test plan
- Signed, passes=3, psums 0x3FFFFF, 5, 100 (COL_WIDTH=11) → `out_data`=104, sat=0, partial=0, one cycle after the third beat.
- Unsigned, passes=2, psums 0x3FFFFF twice → `out_data`=8388606.
- ACC_WIDTH=24, signed, passes=5, psum 0x1FFFFF each → `out_data`=8388607, `out_sat`=1. The next group (passes=5, value 1 each) → 5, sat=0.
- passes=1, `out_ready`=0, three valid beats → the first two are accepted, `psum_ready` low from the third cycle on. Raise `out_ready` → the third beat is accepted the cycle after the first pop, and outputs come out in order.
- passes=4, beats 7 and 8, then `cfg_flush` → output 15 with partial=1, state IDLE, `busy` low after the pop. A flush with counter 0 produces no output.
- Assert `rst` after 2 of 4 beats → `out_valid`=0, `psum_ready`=0. After restart, a group of 1,2,3,4 → 10 (no stale sum).
